// File: rtl/multicycle_datapath_if.sv
// Unified instruction/data memory port for multicycle_datapath.
// One request at a time; an access completes in the cycle mem_ready=1.
//   mem_req    core -> mem  access request
//   mem_we     core -> mem  1 = write, 0 = read (valid while mem_req=1)
//   mem_addr   core -> mem  access address
//   mem_wdata  core -> mem  store data
//   mem_rdata  mem -> core  load/fetch data, sampled when mem_ready=1
//   mem_ready  mem -> core  access completes this cycle
interface multicycle_datapath_if #(
  parameter int unsigned DATA_W = 17
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle ASIP core: datapath with embedded control FSM and a single
// wait-state tolerant memory port shared by fetch, load and store.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (0 = reset)
//   mem            unified memory port (master side)
//   pc             current program counter
//   alu_flags      {N,Z,C,V} flag register
//   instr_retired  one-cycle pulse in the final state of each instruction
//   state          FSM state, for debug
// Instruction word (low 17 bits of IR):
//   [16:15] op  [14:13] cmd/cond  [12] S  [11:8] Rn  [7:4] Rd  [3:0] Rm/imm4
//   branch offset = sign-extended [11:0], scaled by PC_INC
module multicycle_datapath #(
  parameter int unsigned DATA_W   = 17,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_datapath_if.master    mem,
  output logic [DATA_W-1:0]        pc,
  output logic [3:0]               alu_flags,
  output logic                     instr_retired,
  output logic [3:0]               state
);

  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] EXEC   = 4'd2;
  localparam logic [3:0] ALUWB  = 4'd3;
  localparam logic [3:0] MEMADR = 4'd4;
  localparam logic [3:0] MEMRD  = 4'd5;
  localparam logic [3:0] MEMWB  = 4'd6;
  localparam logic [3:0] MEMWR  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);
  localparam logic [DATA_W-1:0] PC_INIT = DATA_W'(RESET_PC);

  // Architectural and pipeline-free multicycle holding registers
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_q;       // operand A (Rn)
  logic [DATA_W-1:0] b_q;       // operand B (Rm or imm4)
  logic [DATA_W-1:0] sd_q;      // store data (Rd)
  logic [DATA_W-1:0] alu_out;   // ALU result or effective address
  logic [DATA_W-1:0] mdr;       // load data
  logic [DATA_W-1:0] regs [0:14];

  // Instruction fields
  logic [1:0] op;
  logic [1:0] cmd;
  logic       s_bit;
  logic [3:0] rn;
  logic [3:0] rd;
  logic [3:0] rm;

  always_comb begin
    op    = ir[16:15];
    cmd   = ir[14:13];
    s_bit = ir[12];
    rn    = ir[11:8];
    rd    = ir[7:4];
    rm    = ir[3:0];
  end

  // Register file read ports; r15 reads as PC+PC_INC with PC already advanced
  logic [DATA_W-1:0] pc_plus;
  logic [DATA_W-1:0] rn_val;
  logic [DATA_W-1:0] rm_val;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] imm_ext;

  always_comb begin
    pc_plus = pc + PC_STEP;
    rn_val  = (rn == 4'd15) ? pc_plus : regs[rn];
    rm_val  = (rm == 4'd15) ? pc_plus : regs[rm];
    rd_val  = (rd == 4'd15) ? pc_plus : regs[rd];
    imm_ext = {{(DATA_W-4){1'b0}}, rm};
  end

  // ALU: SUB is A + ~B + 1 so the carry-out is directly NOT borrow
  logic [DATA_W:0]   add_ext;
  logic [DATA_W:0]   sub_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [3:0]        alu_nzcv;

  always_comb begin
    add_ext = {1'b0, a_q} + {1'b0, b_q};
    sub_ext = {1'b0, a_q} + {1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1};
    alu_res = add_ext[MSB:0];
    alu_c   = alu_flags[1];
    alu_v   = alu_flags[0];
    case (cmd)
      2'b00: begin
        alu_res = add_ext[MSB:0];
        alu_c   = add_ext[DATA_W];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      2'b01: begin
        alu_res = sub_ext[MSB:0];
        alu_c   = sub_ext[DATA_W];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      2'b10: alu_res = a_q & b_q;
      default: alu_res = a_q | b_q;
    endcase
    alu_nzcv = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
  end

  // Branch unit; target is relative to the already-advanced PC
  logic [DATA_W-1:0] br_off;
  logic [DATA_W-1:0] br_target;
  logic              br_taken;

  always_comb begin
    br_off    = {{(DATA_W-12){ir[11]}}, ir[11:0]};
    br_target = pc + br_off * PC_STEP;
    case (cmd)
      2'b00:   br_taken = 1'b1;
      2'b01:   br_taken = alu_flags[2];
      2'b10:   br_taken = !alu_flags[2];
      default: br_taken = 1'b0;
    endcase
  end

  // Memory port and retire pulse; request is masked while reset is held
  // so it drops in the same cycle reset asserts, even mid-access.
  always_comb begin
    mem.mem_req   = reset && ((state == FETCH) || (state == MEMRD) || (state == MEMWR));
    mem.mem_we    = (state == MEMWR);
    mem.mem_addr  = (state == FETCH) ? pc : alu_out;
    mem.mem_wdata = sd_q;
    instr_retired = reset && ((state == ALUWB) || (state == MEMWB) || (state == BRANCH) ||
                              ((state == MEMWR) && mem.mem_ready));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      ir        <= '0;
      alu_flags <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sd_q      <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      regs      <= '{default: '0};
    end else begin
      case (state)
        FETCH: begin
          if (mem.mem_ready) begin
            ir    <= mem.mem_rdata;
            pc    <= pc_plus;
            state <= DECODE;
          end
        end
        DECODE: begin
          a_q  <= rn_val;
          b_q  <= (op == 2'b00) ? rm_val : imm_ext;
          sd_q <= rd_val;
          if (!op[1])     state <= EXEC;
          else if (op[0]) state <= BRANCH;
          else            state <= MEMADR;
        end
        EXEC: begin
          alu_out <= alu_res;
          if (s_bit) alu_flags <= alu_nzcv;
          state <= ALUWB;
        end
        ALUWB: begin
          if (rd == 4'd15) pc <= alu_out;
          else             regs[rd] <= alu_out;
          state <= FETCH;
        end
        MEMADR: begin
          alu_out <= a_q + b_q;
          state   <= cmd[0] ? MEMRD : MEMWR;
        end
        MEMRD: begin
          if (mem.mem_ready) begin
            mdr   <= mem.mem_rdata;
            state <= MEMWB;
          end
        end
        MEMWB: begin
          if (rd == 4'd15) pc <= mdr;
          else             regs[rd] <= mdr;
          state <= FETCH;
        end
        MEMWR: begin
          if (mem.mem_ready) state <= FETCH;
        end
        BRANCH: begin
          if (br_taken) pc <= br_target;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
